line_xfer: RTL and testbench
============================

LINE_XFER -- requirements
Module: line_xfer

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 11, meaning word-address width of main memory.
REQ-002 SHALL have parameter OFS_LEN, default 3, meaning log2 words per cache line (LINE_WORDS = 2**OFS_LEN).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  1  line-transfer request from cache controller.
REQ-006 SHALL have port req_wb  input  1  write back victim line first.
REQ-007 SHALL have port req_rd  input  1  refill requested line.
REQ-008 SHALL have port wb_line  input  ADDR_LEN-OFS_LEN  victim line address.
REQ-009 SHALL have port rd_line  input  ADDR_LEN-OFS_LEN  refill line address.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port wb_idx  output  OFS_LEN  word index whose victim data is requested.
REQ-013 SHALL have port wb_data  input  32  victim word at wb_idx, combinational from cache.
REQ-014 SHALL have port fill_we  output  1  refill word write strobe to cache.
REQ-015 SHALL have port fill_idx  output  OFS_LEN  refill word index.
REQ-016 SHALL have port fill_data  output  32  refill word.
REQ-017 SHALL have port mem_addr  output  ADDR_LEN  memory word address.
REQ-018 SHALL have port mem_wr_req  output  1  memory write strobe.
REQ-019 SHALL have port mem_wr_data  output  32  memory write data.
REQ-020 SHALL have port mem_rd_data  input  32  memory read data; registered, valid the cycle after mem_addr is presented.

Function
REQ-021 SHALL implement states IDLE, WB, RD, DONE; cnt register OFS_LEN+1 bits.
REQ-022 SHALL accept a request only in IDLE with req=1: latch wb_line/rd_line/req_rd, cnt<=0, go WB if req_wb, else RD if req_rd, else DONE.
REQ-023 SHALL ignore req while busy; any req value in non-IDLE states has no effect.
REQ-024 In WB, SHALL drive mem_addr={wb_line_q,cnt[OFS_LEN-1:0]}, mem_wr_req=1, wb_idx=cnt, mem_wr_data=wb_data, for exactly LINE_WORDS cycles.
REQ-025 After the last WB word, SHALL go RD (cnt<=0) if latched req_rd, else DONE.
REQ-026 In RD, SHALL last LINE_WORDS+1 cycles: when cnt<LINE_WORDS drive mem_addr={rd_line_q,cnt}, mem_wr_req=0; when cnt>=1 drive fill_we=1, fill_idx=cnt-1, fill_data=mem_rd_data.
REQ-027 SHALL then enter DONE for one cycle with done=1, then IDLE.
REQ-028 Latency from accepting edge: write-only LINE_WORDS+1 cycles to done; read-only LINE_WORDS+2; both 2*LINE_WORDS+2.
REQ-029 mem_addr, mem_wr_req, wb_idx, fill_we, fill_idx SHALL derive only from registered state/cnt/latched addresses (no combinational path from req).
REQ-030 Outside active phases, mem_wr_req=0, fill_we=0, mem_addr=0, wb_idx=0, fill_idx=0.
REQ-031 Addresses SHALL wrap modulo 2**ADDR_LEN with no error (highest line is legal).

Reset
REQ-032 rst SHALL force IDLE, cnt=0, latched addresses 0, busy=0, done=0, mem_wr_req=0, fill_we=0 immediately (asynchronous).
REQ-033 Reset mid-transfer SHALL abandon the transfer with no done pulse; partially written line is not rolled back.

Structure
REQ-034 A package line_xfer_pkg SHALL hold the state enum and LINE_WORDS-derived constants.
REQ-035 No sub-module SHALL be used; single FSM plus counter.

Verification
REQ-036 Read-only rd_line=1, memory words 8..15 = 60,e3,06,29,86,cf,7d,b3 -> fill_we for 8 cycles, fill_idx 0..7 with those data in order, done 10 cycles after accept.
REQ-037 Write-only wb_line=2, wb_data=0xA0+wb_idx -> mem_wr_req 8 cycles at addr 16..23 with data A0..A7; no fill_we; done 9 cycles after accept.
REQ-038 Both, wb_line=3 rd_line=3 -> write 24..31 then read back identical data on fill_data; done 18 cycles after accept.
REQ-039 req held high through transfer and pulsed mid-RD -> exactly one transfer, single done pulse, next request accepted only after IDLE.
REQ-040 rst asserted mid-WB at word 4 -> mem_wr_req falls same cycle, busy=0, no done; new read request afterwards completes normally.
REQ-041 rd_line=255 (ADDR_LEN=11) -> addresses 2040..2047, no wrap error, done asserted.

Source files
------------

// File: rtl/line_xfer_pkg.sv
// line_xfer_pkg: FSM state encoding and line-geometry constants for line_xfer.
package line_xfer_pkg;
  typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_t;
  localparam int DEF_ADDR_LEN = 11;
  localparam int DEF_OFS_LEN = 3;
  function automatic int line_words(input int ofs_len);
    return 1 << ofs_len;
  endfunction
  localparam int DEF_LINE_WORDS = line_words(DEF_OFS_LEN);
endpackage

// File: rtl/line_xfer.sv
// line_xfer: moves one cache line between cache and memory (victim write-back, then refill).
module line_xfer
  import line_xfer_pkg::*;
#(
  parameter int ADDR_LEN = DEF_ADDR_LEN,
  parameter int OFS_LEN = DEF_OFS_LEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         req_wb,
  input  logic                         req_rd,
  input  logic [ADDR_LEN-OFS_LEN-1:0]  wb_line,
  input  logic [ADDR_LEN-OFS_LEN-1:0]  rd_line,
  output logic                         busy,
  output logic                         done,
  output logic [OFS_LEN-1:0]           wb_idx,
  input  logic [31:0]                  wb_data,
  output logic                         fill_we,
  output logic [OFS_LEN-1:0]           fill_idx,
  output logic [31:0]                  fill_data,
  output logic [ADDR_LEN-1:0]          mem_addr,
  output logic                         mem_wr_req,
  output logic [31:0]                  mem_wr_data,
  input  logic [31:0]                  mem_rd_data
);
  localparam int LINE_WORDS = line_words(OFS_LEN);
  localparam int LINE_LEN = ADDR_LEN - OFS_LEN;
  localparam logic [OFS_LEN:0] LAST_WB = (OFS_LEN+1)'(LINE_WORDS - 1);
  localparam logic [OFS_LEN:0] LAST_RD = (OFS_LEN+1)'(LINE_WORDS);
  state_t state, next;
  logic [OFS_LEN:0] cnt;
  logic [LINE_LEN-1:0] wb_line_q, rd_line_q;
  logic rd_q;
  // cnt restarts on every phase change so each phase starts at word 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wb_line_q <= '0;
      rd_line_q <= '0;
      rd_q <= 1'b0;
    end else begin
      state <= next;
      cnt <= (state == next && (state == WB || state == RD)) ? cnt + 1'b1 : '0;
      if (state == IDLE && req) begin
        wb_line_q <= wb_line;
        rd_line_q <= rd_line;
        rd_q <= req_rd;
      end
    end
  end
  always_comb begin
    next = state;
    unique case (state)
      IDLE: next = !req ? IDLE : req_wb ? WB : req_rd ? RD : DONE;
      WB:   next = cnt != LAST_WB ? WB : rd_q ? RD : DONE;
      RD:   next = cnt != LAST_RD ? RD : DONE;
      default: next = IDLE;
    endcase
  end
  // RD runs one extra cycle: fill lags the address by the memory's read register
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    mem_wr_req = state == WB;
    fill_we = state == RD && cnt != '0;
    wb_idx = mem_wr_req ? cnt[OFS_LEN-1:0] : '0;
    fill_idx = fill_we ? OFS_LEN'(cnt - 1'b1) : '0;
    fill_data = fill_we ? mem_rd_data : '0;
    mem_wr_data = mem_wr_req ? wb_data : '0;
    mem_addr = mem_wr_req ? {wb_line_q, cnt[OFS_LEN-1:0]}
             : (state == RD && !cnt[OFS_LEN]) ? {rd_line_q, cnt[OFS_LEN-1:0]} : '0;
  end
endmodule

// File: tb/tb_line_xfer.sv
// tb_line_xfer: directed checks of line_xfer against a registered-read memory model.
module tb_line_xfer;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, req_wb = 1'b0, req_rd = 1'b0;
  logic [7:0] wb_line = '0, rd_line = '0;
  logic busy, done, fill_we, mem_wr_req;
  logic [2:0] wb_idx, fill_idx;
  logic [31:0] wb_data, fill_data, mem_wr_data, mem_rd_data;
  logic [10:0] mem_addr;
  localparam logic [31:0] WB_BASE = 32'hA0;
  logic [31:0] line1 [8] = '{32'h60, 32'he3, 32'h06, 32'h29, 32'h86, 32'hcf, 32'h7d, 32'hb3};
  logic [31:0] mem [0:2047];
  logic [2047:0] wr_seen;
  logic [31:0] exp_fill [8];
  int checks = 0, errors = 0;

  line_xfer #(.ADDR_LEN(11), .OFS_LEN(3)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wb(req_wb), .req_rd(req_rd),
    .wb_line(wb_line), .rd_line(rd_line), .busy(busy), .done(done),
    .wb_idx(wb_idx), .wb_data(wb_data), .fill_we(fill_we), .fill_idx(fill_idx),
    .fill_data(fill_data), .mem_addr(mem_addr), .mem_wr_req(mem_wr_req),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;
  assign wb_data = WB_BASE + 32'(wb_idx);

  function automatic logic [31:0] pre(input logic [10:0] a);
    return a[10:3] == 8'd1 ? line1[a[2:0]] : a[10:3] == 8'd255 ? 32'(a) : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (rst) wr_seen <= '0;
    else if (mem_wr_req) begin
      mem[mem_addr] <= mem_wr_data;
      wr_seen[mem_addr] <= 1'b1;
    end
    mem_rd_data <= wr_seen[mem_addr] ? mem[mem_addr] : pre(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic wbf, input logic rdf, input logic hold,
                      input logic [7:0] wl, input logic [7:0] rl,
                      input int exp_cycles, input string tag);
    int n, wi, fi, ra;
    logic [10:0] wbase, rbase;
    wbase = {wl, 3'b000};
    rbase = {rl, 3'b000};
    wi = 0; fi = 0; ra = 0;
    req = 1'b1; req_wb = wbf; req_rd = rdf; wb_line = wl; rd_line = rl;
    @(negedge clk);
    n = 1;
    req = hold;
    req_wb = ~wbf; req_rd = ~rdf; wb_line = ~wl; rd_line = ~rl;
    while (1) begin
      if (mem_wr_req) begin
        chk({tag, "_waddr"}, 32'(mem_addr), 32'(wbase) + 32'(wi));
        chk({tag, "_wdata"}, mem_wr_data, WB_BASE + 32'(wi));
        wi++;
      end
      if (fill_we) begin
        chk({tag, "_fidx"}, 32'(fill_idx), 32'(fi));
        chk({tag, "_fdata"}, fill_data, exp_fill[fi[2:0]]);
        fi++;
      end
      if (busy && !mem_wr_req && !done && ra < 8) begin
        chk({tag, "_raddr"}, 32'(mem_addr), 32'(rbase) + 32'(ra));
        ra++;
      end
      if (done || n >= 40) break;
      @(negedge clk);
      n++;
      if (hold) req = ~req;
    end
    req = hold;
    chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    chk({tag, "_wcount"}, 32'(wi), wbf ? 32'd8 : 32'd0);
    chk({tag, "_fcount"}, 32'(fi), rdf ? 32'd8 : 32'd0);
    chk({tag, "_rcount"}, 32'(ra), rdf ? 32'd8 : 32'd0);
    req_wb = wbf; req_rd = rdf; wb_line = wl; rd_line = rl;
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr", 32'(mem_wr_req), 32'd0);
    chk("rst_fill", 32'(fill_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) exp_fill[i] = line1[i];
    xfer(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 10, "rd");
    xfer(1'b1, 1'b0, 1'b0, 8'd2, 8'd0, 9, "wb");
    for (int i = 0; i < 8; i++) exp_fill[i] = WB_BASE + 32'(i);
    xfer(1'b1, 1'b1, 1'b0, 8'd3, 8'd3, 18, "wbrd");
    for (int i = 0; i < 8; i++) exp_fill[i] = line1[i];
    xfer(1'b0, 1'b1, 1'b1, 8'd0, 8'd1, 10, "hold");
    @(negedge clk);
    chk("reaccept_busy", 32'(busy), 32'd1);
    req = 1'b0;
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    chk("reaccept_end", 32'(busy), 32'd0);
    req = 1'b1; req_wb = 1'b1; req_rd = 1'b0; wb_line = 8'd2;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_wr", 32'(mem_wr_req), 32'd1);
    chk("mid_addr", 32'(mem_addr), 32'd20);
    rst = 1'b1;
    #1;
    chk("arst_wr", 32'(mem_wr_req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    xfer(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 10, "rd_after_rst");
    for (int i = 0; i < 8; i++) exp_fill[i] = 32'd2040 + 32'(i);
    xfer(1'b0, 1'b1, 1'b0, 8'd0, 8'd255, 10, "top");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
